// File: rtl/result_collector.sv
// Checks adder results against a delayed a+b model, counts matches/mismatches
// and packs the checked result bytes into 32-bit words queued in an output FIFO.
module result_collector #(
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TOTAL      = 2000000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        in_valid_i,
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   input  logic [7:0]  res_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   input  logic        word_ready_i,
   output logic [31:0] match_cnt_o,
   output logic [31:0] mismatch_cnt_o,
   output logic        overflow_o,
   output logic        done_o
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam logic [31:0] TOTAL_W = 32'(TOTAL);
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

   logic              armed;
   logic [31:0]       issued, checked;
   logic [LATENCY-1:0] pv;
   logic [7:0]        pe [LATENCY];
   logic              accept, check, hit, last;
   logic [1:0]        pk_cnt;
   logic [31:0]       pk_data, pk_next;
   logic              push_q;
   logic [31:0]       push_word;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              full, pop, wr_en, done_q, ovf_q;

   // One-flop release stage: transactions are taken from the second edge after release.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) armed <= 1'b0;
      else          armed <= 1'b1;
   end

   assign accept = in_valid_i && armed && (issued != TOTAL_W);
   assign check  = pv[LATENCY-1];
   assign hit    = (res_i == pe[LATENCY-1]);
   assign last   = check && (checked == TOTAL_W - 32'd1);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         pv <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) pe[i] <= '0;
      end else begin
         pv[0] <= accept;
         pe[0] <= a_i + b_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         issued         <= '0;
         checked        <= '0;
         match_cnt_o    <= '0;
         mismatch_cnt_o <= '0;
      end else begin
         if (accept) issued <= issued + 32'd1;
         if (check) begin
            checked <= checked + 32'd1;
            if (hit && match_cnt_o != '1)     match_cnt_o    <= match_cnt_o + 32'd1;
            if (!hit && mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + 32'd1;
         end
      end
   end

   always_comb begin
      pk_next = pk_data;
      case (pk_cnt)
         2'd0:    pk_next[7:0]   = res_i;
         2'd1:    pk_next[15:8]  = res_i;
         2'd2:    pk_next[23:16] = res_i;
         default: pk_next[31:24] = res_i;
      endcase
   end

   // Packer clears after each hand-off, so a flushed partial word has zero upper bytes.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         pk_cnt    <= '0;
         pk_data   <= '0;
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         push_q <= 1'b0;
         if (check) begin
            if (pk_cnt == 2'd3 || last) begin
               push_q    <= 1'b1;
               push_word <= pk_next;
               pk_cnt    <= '0;
               pk_data   <= '0;
            end else begin
               pk_cnt  <= pk_cnt + 2'd1;
               pk_data <= pk_next;
            end
         end
      end
   end

   assign full  = (count == DEPTH_W);
   assign pop   = (count != '0) && word_ready_i;
   assign wr_en = push_q && (!full || pop);

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_q && full && !pop) ovf_q <= 1'b1;
         if (checked == TOTAL_W && pk_cnt == 2'd0 && !push_q && count == '0) done_q <= 1'b1;
      end
   end

   assign word_valid_o = (count != '0);
   assign word_o       = word_valid_o ? mem[rd_ptr] : '0;
   assign overflow_o   = ovf_q;
   assign done_o       = done_q;

endmodule
